// File: rtl/spi_master_param_if.sv
// Register-bus and SPI pin bundle for spi_master_param.
// The slave modport is the controller's view; master is the CPU/pin side.
interface spi_master_param_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1
);
   logic              i_cs;
   logic              i_wr;
   logic              i_rd;
   logic [1:0]        i_address;
   logic [DATA_W-1:0] i_data;
   logic [DATA_W-1:0] o_data;
   logic              o_sclk;
   logic              o_mosi;
   logic              i_miso;
   logic [NUM_CS-1:0] o_cs_n;

   modport slave (
      input  i_cs, i_wr, i_rd, i_address, i_data, i_miso,
      output o_data, o_sclk, o_mosi, o_cs_n
   );

   modport master (
      output i_cs, i_wr, i_rd, i_address, i_data, i_miso,
      input  o_data, o_sclk, o_mosi, o_cs_n
   );
endinterface

// File: rtl/spi_master_param.sv
// Register-mapped SPI master: four SPI modes, MSB/LSB-first, DATA_W-bit words,
// NUM_CS active-low selects, done/overrun status and a programmable SCLK divider.
//
// state   | meaning
// S_IDLE  | no transfer; sclk=CPOL, selects high, mosi low
// S_SETUP | one half-period with the select asserted before the first SCLK edge
// S_SHIFT | 2*DATA_W half-periods, each opened by an SCLK edge
// S_HOLD  | one half-period with sclk back at CPOL, select still low
module spi_master_param #(
   parameter int DATA_W  = 8,
   parameter int NUM_CS  = 1,
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 3
) (
   input logic                i_clk,
   input logic                i_rst_n,
   spi_master_param_if.slave  bus
);
   localparam int         EDGES  = 2 * DATA_W;
   localparam int         EC_W   = $clog2(EDGES + 1);
   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_DIV  = 2'd2;
   localparam logic [1:0] A_CTRL = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              cpha_q, cpha_d;
   logic              cpol_q, cpol_d;
   logic              lsb_q, lsb_d;
   logic [3:0]        cs_sel_q, cs_sel_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic [NUM_CS-1:0] cs_dec;

   logic              wr_en, rd_en, start, busy;
   logic              half_end, last_edge, edge_fire, leading;
   logic              do_drive, do_sample, finish;
   logic [EC_W-1:0]   edge_num;

   function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                    input logic lsb);
      return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
   endfunction

   assign wr_en     = bus.i_cs & bus.i_wr;
   assign rd_en     = bus.i_cs & bus.i_rd & ~bus.i_wr;
   assign busy      = (state_q != S_IDLE);
   assign start     = wr_en && (bus.i_address == A_DATA) && !busy;
   assign half_end  = (div_cnt_q == div_q);
   assign last_edge = (edge_cnt_q == EC_W'(EDGES));
   assign edge_num  = edge_cnt_q + 1'b1;
   assign leading   = edge_num[0];
   assign edge_fire = half_end && ((state_q == S_SETUP) || ((state_q == S_SHIFT) && !last_edge));
   // CPHA=0 preloads bit 0 at SETUP entry, so only trailing edges 2..2W-2 advance MOSI
   assign do_drive  = edge_fire && (cpha_q ? leading
                                           : (!leading && (edge_num <= EC_W'(EDGES - 2))));
   assign do_sample = edge_fire && (cpha_q ? !leading : leading);
   assign finish    = (state_q == S_HOLD) && half_end;

   always_comb begin
      for (int i = 0; i < NUM_CS; i++) begin
         cs_dec[i] = (cs_sel_q != 4'(i));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         div_q      <= DIV_W'(DIV_RST);
         cpha_q     <= 1'b0;
         cpol_q     <= 1'b0;
         lsb_q      <= 1'b0;
         cs_sel_q   <= '0;
         tx_q       <= '0;
         rx_sh_q    <= '0;
         rx_q       <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         div_q      <= div_d;
         cpha_q     <= cpha_d;
         cpol_q     <= cpol_d;
         lsb_q      <= lsb_d;
         cs_sel_q   <= cs_sel_d;
         tx_q       <= tx_d;
         rx_sh_q    <= rx_sh_d;
         rx_q       <= rx_d;
         rdata_q    <= rdata_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            div_cnt_d = '0;
            if (start) begin
               state_d    = S_SETUP;
               edge_cnt_d = '0;
            end
         end
         S_SETUP: begin
            if (half_end) begin
               state_d    = S_SHIFT;
               div_cnt_d  = '0;
               edge_cnt_d = edge_num;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (half_end) begin
               div_cnt_d = '0;
               if (last_edge) state_d = S_HOLD;
               else           edge_cnt_d = edge_num;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (half_end) begin
               state_d   = S_IDLE;
               div_cnt_d = '0;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_d    = div_q;
      cpha_d   = cpha_q;
      cpol_d   = cpol_q;
      lsb_d    = lsb_q;
      cs_sel_d = cs_sel_q;
      tx_d     = tx_q;
      rx_sh_d  = rx_sh_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      done_d   = done_q;
      ovr_d    = ovr_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      cs_n_d   = cs_n_q;

      if (wr_en) begin
         unique case (bus.i_address)
            A_DATA: if (busy) ovr_d = 1'b1;
            A_STAT: begin
               if (bus.i_data[1]) done_d = 1'b0;
               if (bus.i_data[2]) ovr_d  = 1'b0;
            end
            A_DIV:  if (!busy) div_d = DIV_W'(bus.i_data);
            A_CTRL: begin
               if (!busy) begin
                  cpha_d   = bus.i_data[0];
                  cpol_d   = bus.i_data[1];
                  lsb_d    = bus.i_data[2];
                  cs_sel_d = bus.i_data[7:4];
               end
            end
            default: ;
         endcase
      end else if (rd_en) begin
         unique case (bus.i_address)
            A_DATA: begin
               rdata_d = rx_q;
               done_d  = 1'b0;
            end
            A_STAT:  rdata_d = DATA_W'({ovr_q, done_q, busy});
            A_DIV:   rdata_d = DATA_W'(div_q);
            A_CTRL:  rdata_d = DATA_W'({cs_sel_q, 1'b0, lsb_q, cpol_q, cpha_q});
            default: ;
         endcase
      end

      // idle SCLK follows a CPOL write in the same cycle it lands
      if (!busy) sclk_d = cpol_d;

      if (start) begin
         cs_n_d = cs_dec;
         if (!cpha_q) begin
            mosi_d = first_bit(bus.i_data, lsb_q);
            tx_d   = shift_word(bus.i_data, lsb_q);
         end else begin
            tx_d   = bus.i_data;
         end
      end

      if (edge_fire) sclk_d = ~sclk_q;

      if (do_drive) begin
         mosi_d = first_bit(tx_q, lsb_q);
         tx_d   = shift_word(tx_q, lsb_q);
      end

      if (do_sample) begin
         rx_sh_d = lsb_q ? {bus.i_miso, rx_sh_q[DATA_W-1:1]}
                         : {rx_sh_q[DATA_W-2:0], bus.i_miso};
      end

      if (finish) begin
         rx_d   = rx_sh_q;
         cs_n_d = '1;
         mosi_d = 1'b0;
         done_d = 1'b1;
      end
   end

   assign bus.o_data = rdata_q;
   assign bus.o_sclk = sclk_q;
   assign bus.o_mosi = mosi_q;
   assign bus.o_cs_n = cs_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: mode 0/3 transfers, overrun, frozen
// DIV/CTRL, chip-select decode, read/write collision and mid-transfer reset.
module tb_spi_master_param;
   localparam int DATA_W  = 8;
   localparam int NUM_CS  = 4;
   localparam int DIV_W   = 8;
   localparam int DIV_RST = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_param_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) bus ();

   spi_master_param #(
      .DATA_W (DATA_W),
      .NUM_CS (NUM_CS),
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic       loop_en   = 1'b1;
   logic       miso_drv  = 1'b0;
   logic [7:0] miso_word = 8'h00;
   logic       mode_cpha = 1'b0;
   logic       mode_cpol = 1'b0;

   assign bus.i_miso = loop_en ? bus.o_mosi : miso_drv;

   // pin monitor: runs just after each active edge, only while a select is low
   int                edges_total  = 0;
   int                cs_low_total = 0;
   int                miso_idx     = 0;
   logic              sclk_prev    = 1'b0;
   logic [7:0]        mosi_seq     = 8'h00;
   logic [NUM_CS-1:0] cs_seen      = '1;

   always @(posedge clk) begin
      #2;
      sclk_prev <= bus.o_sclk;
      if (bus.o_cs_n != '1) begin
         cs_low_total <= cs_low_total + 1;
         cs_seen      <= bus.o_cs_n;
         if (bus.o_sclk != sclk_prev) begin
            edges_total <= edges_total + 1;
            if ((bus.o_sclk != mode_cpol) == !mode_cpha)
               mosi_seq <= {mosi_seq[6:0], bus.o_mosi};
            if ((bus.o_sclk != mode_cpol) && (miso_idx < 8)) begin
               miso_drv <= miso_word[miso_idx];
               miso_idx <= miso_idx + 1;
            end
         end
      end else begin
         miso_idx <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.i_cs = 1'b1; bus.i_wr = 1'b1; bus.i_rd = 1'b0;
      bus.i_address = a; bus.i_data = d;
      @(negedge clk);
      bus.i_cs = 1'b0; bus.i_wr = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      bus.i_cs = 1'b1; bus.i_rd = 1'b1; bus.i_wr = 1'b0;
      bus.i_address = a;
      @(negedge clk);
      bus.i_cs = 1'b0; bus.i_rd = 1'b0;
      d = bus.o_data;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((bus.o_cs_n != '1) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.o_cs_n == '1), 32'd1);
   endtask

   initial begin
      logic [7:0] r;
      int e0, c0, n;
      bus.i_cs = 1'b0; bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      bus.i_address = 2'd0; bus.i_data = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_cs_n",  32'(bus.o_cs_n), 'hF);
      check("rst_sclk",  32'(bus.o_sclk), 0);
      check("rst_mosi",  32'(bus.o_mosi), 0);
      check("rst_odata", 32'(bus.o_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(2'd1, r); check("rst_status", 32'(r), 0);
      rd(2'd2, r); check("rst_div",    32'(r), DIV_RST);
      rd(2'd3, r); check("rst_ctrl",   32'(r), 0);
      rd(2'd0, r); check("rst_rx",     32'(r), 0);

      // mode 0, DIV=1, MISO looped back, TX=0xA5
      mode_cpha = 1'b0; mode_cpol = 1'b0; loop_en = 1'b1;
      wr(2'd2, 8'd1);
      wr(2'd3, 8'h00);
      e0 = edges_total; c0 = cs_low_total;
      wr(2'd0, 8'hA5);
      check("m0_cs_low", 32'(bus.o_cs_n), 'hE);
      wait_idle("m0_idle");
      check("m0_busy_cycles", cs_low_total - c0, 36);
      check("m0_edges",       edges_total - e0, 16);
      check("m0_mosi_bits",   32'(mosi_seq), 'hA5);
      check("m0_sclk_idle",   32'(bus.o_sclk), 0);
      check("m0_mosi_idle",   32'(bus.o_mosi), 0);
      rd(2'd1, r); check("m0_status_done", 32'(r), 'h2);
      rd(2'd0, r); check("m0_rx",          32'(r), 'hA5);
      rd(2'd1, r); check("m0_done_clr",    32'(r), 'h0);

      // mode 3, LSB-first, DIV=0, slave returns 0x81
      mode_cpha = 1'b1; mode_cpol = 1'b1; loop_en = 1'b0; miso_word = 8'h81;
      wr(2'd3, 8'h07);
      wr(2'd2, 8'h00);
      check("m3_sclk_idle_hi", 32'(bus.o_sclk), 1);
      e0 = edges_total; c0 = cs_low_total;
      wr(2'd0, 8'h3C);
      wait_idle("m3_idle");
      check("m3_busy_cycles", cs_low_total - c0, 18);
      check("m3_edges",       edges_total - e0, 16);
      check("m3_mosi_bits",   32'(mosi_seq), 'h3C);
      check("m3_sclk_end",    32'(bus.o_sclk), 1);
      rd(2'd0, r); check("m3_rx", 32'(r), 'h81);

      // overrun: DATA write while busy is dropped
      mode_cpha = 1'b0; mode_cpol = 1'b0; loop_en = 1'b1;
      wr(2'd3, 8'h00);
      wr(2'd2, 8'h01);
      wr(2'd0, 8'h12);
      repeat (4) @(negedge clk);
      wr(2'd0, 8'hFF);
      rd(2'd1, r); check("ovr_status_busy", 32'(r), 'h5);
      wait_idle("ovr_idle");
      check("ovr_wire_word", 32'(mosi_seq), 'h12);
      rd(2'd0, r); check("ovr_rx",        32'(r), 'h12);
      rd(2'd1, r); check("ovr_status",    32'(r), 'h4);
      wr(2'd1, 8'h04);
      rd(2'd1, r); check("ovr_w1c",       32'(r), 'h0);

      // DIV/CTRL frozen while busy; cs_sel=2 decode
      wr(2'd3, 8'h20);
      c0 = cs_low_total;
      wr(2'd0, 8'h55);
      check("cs2_only", 32'(bus.o_cs_n), 'hB);
      wr(2'd2, 8'd9);
      wr(2'd3, 8'h07);
      rd(2'd2, r); check("div_frozen",  32'(r), 'h1);
      rd(2'd3, r); check("ctrl_frozen", 32'(r), 'h20);
      wait_idle("cs2_idle");
      check("cs2_busy_h2", cs_low_total - c0, 36);
      check("cs2_seen",    32'(cs_seen), 'hB);

      // simultaneous read+write to DIV acts as write only
      rd(2'd3, r); check("rw_pre", 32'(r), 'h20);
      bus.i_cs = 1'b1; bus.i_wr = 1'b1; bus.i_rd = 1'b1;
      bus.i_address = 2'd2; bus.i_data = 8'd5;
      @(negedge clk);
      bus.i_cs = 1'b0; bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("rw_odata_hold", 32'(bus.o_data), 'h20);
      rd(2'd2, r); check("rw_div_written", 32'(r), 'h5);

      // DATA write in the cycle busy falls is treated as busy
      wr(2'd3, 8'h00);
      wr(2'd2, 8'h00);
      wr(2'd1, 8'h06);
      c0 = cs_low_total;
      wr(2'd0, 8'h96);
      repeat (17) @(negedge clk);
      check("fall_still_busy", 32'(bus.o_cs_n), 'hE);
      wr(2'd0, 8'h69);
      check("fall_no_restart", 32'(bus.o_cs_n), 'hF);
      check("fall_busy_cycles", cs_low_total - c0, 18);
      @(negedge clk);
      check("fall_idle_hold", 32'(bus.o_cs_n), 'hF);
      rd(2'd1, r); check("fall_status", 32'(r), 'h6);
      rd(2'd0, r); check("fall_rx",     32'(r), 'h96);

      // async reset at SCLK edge 5
      wr(2'd1, 8'h06);
      e0 = edges_total;
      wr(2'd0, 8'h5A);
      n = 0;
      while (((edges_total - e0) < 5) && (n < 500)) begin
         @(negedge clk);
         n++;
      end
      check("rst5_reached", edges_total - e0, 5);
      check("rst5_sclk_pre", 32'(bus.o_sclk), 1);
      rst_n = 1'b0;
      #1;
      check("rst5_cs_n", 32'(bus.o_cs_n), 'hF);
      check("rst5_sclk", 32'(bus.o_sclk), 0);
      check("rst5_mosi", 32'(bus.o_mosi), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rd(2'd1, r); check("rst5_status", 32'(r), 0);
      rd(2'd2, r); check("rst5_div",    32'(r), DIV_RST);
      rd(2'd0, r); check("rst5_rx",     32'(r), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
